// File: rtl/lock_sequencer_if.sv
// Keypad, timer and display/status signals of the lock sequencer.
// The master side is the keypad/timer front end; the slave side is the sequencer.
interface lock_sequencer_if #(
  parameter int DIGITS = 6
);
  logic                  tick;
  logic                  key_valid;
  logic [3:0]            key;
  logic                  cancel;
  logic                  set_req;
  logic [4*DIGITS-1:0]   disp;
  logic [2:0]            digit_cnt;
  logic                  unlocked;
  logic                  alarm;
  logic [1:0]            err_cnt;
  logic                  key_err;
  logic [2:0]            state;

  modport master (
    output tick, key_valid, key, cancel, set_req,
    input  disp, digit_cnt, unlocked, alarm, err_cnt, key_err, state
  );

  modport slave (
    input  tick, key_valid, key, cancel, set_req,
    output disp, digit_cnt, unlocked, alarm, err_cnt, key_err, state
  );
endinterface

// File: rtl/lock_sequencer.sv
// Six-digit lock controller: digit entry, password compare/change,
// failure counting and timed lockout. All outputs are registered.
module lock_sequencer #(
  parameter int DIGITS     = 6,
  parameter int MAX_ERR    = 3,
  parameter int LOCK_TICKS = 10,
  parameter int OPEN_TICKS = 5
) (
  input  logic              clk,
  input  logic              clr,
  lock_sequencer_if.slave   bus
);
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_SET     = 3'd4,
    S_FAIL    = 3'd5,
    S_LOCKOUT = 3'd6
  } state_t;

  localparam int DW   = 4 * DIGITS;
  localparam int TMAX = (LOCK_TICKS > OPEN_TICKS) ? LOCK_TICKS : OPEN_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  state_t          state_q, state_nxt;
  logic [DW-1:0]   entry_q, entry_nxt, entry_fill;
  logic [DW-1:0]   pw_q, pw_nxt;
  logic [2:0]      cnt_q, cnt_nxt;
  logic [1:0]      err_q, err_nxt;
  logic [TW-1:0]   tick_q, tick_nxt;
  logic            kerr_nxt;
  logic            key_ok, key_bad, last_digit;

  assign key_ok     = bus.key_valid && (bus.key <= 4'd9);
  assign key_bad    = bus.key_valid && (bus.key >  4'd9);
  assign last_digit = (cnt_q == 3'(DIGITS - 1));

  // Entry buffer with the current key dropped into the next free nibble, MS first.
  always_comb begin
    entry_fill = entry_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q == 3'(i)) entry_fill[DW-4-4*i +: 4] = bus.key;
    end
  end

  always_comb begin
    state_nxt = state_q;
    entry_nxt = entry_q;
    pw_nxt    = pw_q;
    cnt_nxt   = cnt_q;
    err_nxt   = err_q;
    tick_nxt  = tick_q;
    kerr_nxt  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (key_bad) begin
          kerr_nxt = 1'b1;
        end else if (key_ok) begin
          entry_nxt = entry_fill;
          cnt_nxt   = 3'd1;
          state_nxt = S_ENTRY;
        end
      end
      // ENTRY and SET capture digits identically; they differ in where they go next.
      S_ENTRY, S_SET: begin
        if (bus.cancel) begin
          if (state_q == S_ENTRY) begin
            entry_nxt = '0;
            cnt_nxt   = '0;
            state_nxt = S_IDLE;
          end else begin
            tick_nxt  = '0;
            state_nxt = S_OPEN;
          end
        end else if (key_bad) begin
          kerr_nxt = 1'b1;
        end else if (key_ok) begin
          entry_nxt = entry_fill;
          cnt_nxt   = cnt_q + 3'd1;
          if (last_digit) begin
            if (state_q == S_ENTRY) begin
              state_nxt = S_CHECK;
            end else begin
              pw_nxt    = entry_fill;
              tick_nxt  = '0;
              state_nxt = S_OPEN;
            end
          end
        end
      end
      S_CHECK: begin
        if (entry_q == pw_q) begin
          err_nxt   = '0;
          tick_nxt  = '0;
          state_nxt = S_OPEN;
        end else begin
          state_nxt = S_FAIL;
        end
      end
      // err_cnt stays at MAX_ERR-1 through lockout rather than wrapping.
      S_FAIL: begin
        if (int'(err_q) + 1 == MAX_ERR) begin
          tick_nxt  = '0;
          state_nxt = S_LOCKOUT;
        end else begin
          err_nxt   = err_q + 2'd1;
          entry_nxt = '0;
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end
      end
      S_OPEN: begin
        if (bus.set_req) begin
          entry_nxt = '0;
          cnt_nxt   = '0;
          state_nxt = S_SET;
        end else if (bus.tick) begin
          tick_nxt = tick_q + 1'b1;
          if (int'(tick_q) + 1 == OPEN_TICKS) begin
            tick_nxt  = '0;
            entry_nxt = '0;
            cnt_nxt   = '0;
            state_nxt = S_IDLE;
          end
        end
      end
      S_LOCKOUT: begin
        if (bus.tick) begin
          tick_nxt = tick_q + 1'b1;
          if (int'(tick_q) + 1 == LOCK_TICKS) begin
            tick_nxt  = '0;
            err_nxt   = '0;
            entry_nxt = '0;
            cnt_nxt   = '0;
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= S_IDLE;
      entry_q      <= '0;
      pw_q         <= '0;
      cnt_q        <= '0;
      err_q        <= '0;
      tick_q       <= '0;
      bus.disp     <= '0;
      bus.unlocked <= 1'b0;
      bus.alarm    <= 1'b0;
      bus.key_err  <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      entry_q      <= entry_nxt;
      pw_q         <= pw_nxt;
      cnt_q        <= cnt_nxt;
      err_q        <= err_nxt;
      tick_q       <= tick_nxt;
      bus.disp     <= (state_nxt == S_LOCKOUT) ? {DIGITS{4'hE}} : entry_nxt;
      bus.unlocked <= (state_nxt == S_OPEN) || (state_nxt == S_SET);
      bus.alarm    <= (state_nxt == S_LOCKOUT);
      bus.key_err  <= kerr_nxt;
    end
  end

  assign bus.state     = state_q;
  assign bus.digit_cnt = cnt_q;
  assign bus.err_cnt   = err_q;
endmodule

// File: tb/tb_lock_sequencer.sv
// Scoreboard bench for lock_sequencer: a behavioural lock model queues the
// expected outputs for every driven cycle, which are popped after the edge.
module tb_lock_sequencer;
  localparam int DIGITS     = 6;
  localparam int MAX_ERR    = 3;
  localparam int LOCK_TICKS = 10;
  localparam int OPEN_TICKS = 5;

  localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_OPEN = 3;
  localparam int M_SET = 4, M_FAIL = 5, M_LOCK = 6;

  logic clk = 1'b0;
  logic clr = 1'b0;

  lock_sequencer_if #(.DIGITS(DIGITS)) bus ();

  lock_sequencer #(
    .DIGITS(DIGITS), .MAX_ERR(MAX_ERR),
    .LOCK_TICKS(LOCK_TICKS), .OPEN_TICKS(OPEN_TICKS)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic [23:0] disp;
    logic [2:0]  cnt;
    logic        ul;
    logic        al;
    logic [1:0]  err;
    logic        ke;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  int m_st = M_IDLE, m_cnt = 0, m_err = 0, m_tk = 0;
  int m_buf[DIGITS];
  int m_pw[DIGITS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s at %0t: got %0h want %0h", tag, $time, got, want);
  endtask

  function automatic logic [23:0] pack_buf();
    logic [23:0] v = '0;
    for (int i = 0; i < DIGITS; i++) v[23-4*i -: 4] = 4'(m_buf[i]);
    return v;
  endfunction

  // Reference lock: digits kept as an integer array, stepped once per clock.
  task automatic model(input bit c, input bit tk, input bit kv, input logic [3:0] k,
                       input bit cn, input bit sr);
    int   ns = m_st;
    bit   ke = 0;
    bit   wipe = 0;
    bit   match;
    exp_t e;
    if (c) begin
      ns = M_IDLE; m_cnt = 0; m_err = 0; m_tk = 0;
      for (int i = 0; i < DIGITS; i++) begin m_buf[i] = 0; m_pw[i] = 0; end
    end else begin
      case (m_st)
        M_IDLE: begin
          if (kv && k > 9) ke = 1;
          else if (kv) begin m_buf[0] = int'(k); m_cnt = 1; ns = M_ENTRY; end
        end
        M_ENTRY, M_SET: begin
          if (cn) begin
            if (m_st == M_ENTRY) begin wipe = 1; ns = M_IDLE; end
            else begin ns = M_OPEN; m_tk = 0; end
          end else if (kv && k > 9) ke = 1;
          else if (kv) begin
            m_buf[m_cnt] = int'(k);
            m_cnt++;
            if (m_cnt == DIGITS) begin
              if (m_st == M_ENTRY) ns = M_CHECK;
              else begin m_pw = m_buf; ns = M_OPEN; m_tk = 0; end
            end
          end
        end
        M_CHECK: begin
          match = 1;
          for (int i = 0; i < DIGITS; i++) if (m_buf[i] != m_pw[i]) match = 0;
          if (match) begin m_err = 0; m_tk = 0; ns = M_OPEN; end
          else ns = M_FAIL;
        end
        M_FAIL: begin
          if (m_err + 1 == MAX_ERR) begin ns = M_LOCK; m_tk = 0; end
          else begin m_err++; wipe = 1; ns = M_IDLE; end
        end
        M_OPEN: begin
          if (sr) begin wipe = 1; ns = M_SET; end
          else if (tk) begin
            m_tk++;
            if (m_tk == OPEN_TICKS) begin wipe = 1; ns = M_IDLE; end
          end
        end
        M_LOCK: begin
          if (tk) begin
            m_tk++;
            if (m_tk == LOCK_TICKS) begin m_err = 0; wipe = 1; ns = M_IDLE; end
          end
        end
        default: ns = M_IDLE;
      endcase
    end
    if (wipe) begin
      m_cnt = 0;
      for (int i = 0; i < DIGITS; i++) m_buf[i] = 0;
    end
    m_st   = ns;
    e.st   = 3'(ns);
    e.disp = (ns == M_LOCK) ? 24'hEEEEEE : pack_buf();
    e.cnt  = 3'(m_cnt);
    e.ul   = (ns == M_OPEN) || (ns == M_SET);
    e.al   = (ns == M_LOCK);
    e.err  = 2'(m_err);
    e.ke   = ke;
    sb.push_back(e);
  endtask

  task automatic step(input bit c, input bit tk, input bit kv, input logic [3:0] k,
                      input bit cn, input bit sr);
    exp_t e;
    clr = c; bus.tick = tk; bus.key_valid = kv; bus.key = k;
    bus.cancel = cn; bus.set_req = sr;
    model(c, tk, kv, k, cn, sr);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("state",     32'(bus.state),     32'(e.st));
    check("disp",      32'(bus.disp),      32'(e.disp));
    check("digit_cnt", 32'(bus.digit_cnt), 32'(e.cnt));
    check("unlocked",  32'(bus.unlocked),  32'(e.ul));
    check("alarm",     32'(bus.alarm),     32'(e.al));
    check("err_cnt",   32'(bus.err_cnt),   32'(e.err));
    check("key_err",   32'(bus.key_err),   32'(e.ke));
  endtask

  task automatic nop();                     step(0, 0, 0, 4'd0, 0, 0); endtask
  task automatic key_in(input logic [3:0] k); step(0, 0, 1, k, 0, 0);  endtask
  task automatic do_clr();                  step(1, 0, 0, 4'd0, 0, 0); endtask
  task automatic do_cancel();               step(0, 0, 0, 4'd0, 1, 0); endtask
  task automatic do_set();                  step(0, 0, 0, 4'd0, 0, 1); endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 1, 0, 4'd0, 0, 0);
      nop();
    end
  endtask

  task automatic enter(input logic [23:0] code);
    for (int i = 0; i < DIGITS; i++) key_in(code[23-4*i -: 4]);
  endtask

  task automatic wrong_entry();
    enter(24'h999999);
    nop();
    nop();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_state"}, 32'(bus.state), 32'd0);
    check({tag, "_disp"},  32'(bus.disp),  32'd0);
    check({tag, "_cnt"},   32'(bus.digit_cnt), 32'd0);
    check({tag, "_unl"},   32'(bus.unlocked), 32'd0);
    check({tag, "_alarm"}, 32'(bus.alarm), 32'd0);
    check({tag, "_err"},   32'(bus.err_cnt), 32'd0);
  endtask

  initial begin
    bus.tick = 0; bus.key_valid = 0; bus.key = 0; bus.cancel = 0; bus.set_req = 0;
    for (int i = 0; i < DIGITS; i++) begin m_buf[i] = 0; m_pw[i] = 0; end

    do_clr();
    check_zero("reset");

    // Default password 000000: CHECK after the sixth key, OPEN one cycle later.
    enter(24'h000000);
    check("check_state", 32'(bus.state), 32'd2);
    nop();
    check("open_state", 32'(bus.state), 32'd3);
    check("open_unl", 32'(bus.unlocked), 32'd1);

    do_set();
    enter(24'h123456);
    check("set_to_open", 32'(bus.state), 32'd3);
    key_in(4'd9);
    key_in(4'hC);
    check("open_no_kerr", 32'(bus.key_err), 32'd0);
    ticks(OPEN_TICKS);
    check("open_timeout", 32'(bus.state), 32'd0);

    enter(24'h123456);
    nop();
    check("new_pw_open", 32'(bus.state), 32'd3);
    ticks(OPEN_TICKS);
    enter(24'h123457);
    check("disp_entry", 32'(bus.disp), 32'h123457);
    nop();
    check("fail_state", 32'(bus.state), 32'd5);
    nop();
    check("fail_err1", 32'(bus.err_cnt), 32'd1);

    wrong_entry();
    wrong_entry();
    check("lock_state", 32'(bus.state), 32'd6);
    check("lock_alarm", 32'(bus.alarm), 32'd1);
    check("lock_disp", 32'(bus.disp), 32'hEEEEEE);
    check("lock_err", 32'(bus.err_cnt), 32'd2);
    key_in(4'd1);
    do_cancel();
    do_set();
    ticks(LOCK_TICKS);
    check("unlock_idle", 32'(bus.state), 32'd0);
    check("unlock_alarm", 32'(bus.alarm), 32'd0);
    check("unlock_err", 32'(bus.err_cnt), 32'd0);

    key_in(4'd1);
    key_in(4'd2);
    key_in(4'hB);
    check("kerr_pulse", 32'(bus.key_err), 32'd1);
    check("kerr_cnt", 32'(bus.digit_cnt), 32'd2);
    nop();
    check("kerr_clear", 32'(bus.key_err), 32'd0);
    step(0, 0, 1, 4'd3, 1, 0);
    check("cancel_idle", 32'(bus.state), 32'd0);
    check("cancel_cnt", 32'(bus.digit_cnt), 32'd0);

    // clr mid-entry wipes the stored 123456 back to 000000.
    key_in(4'd1); key_in(4'd2); key_in(4'd3);
    do_clr();
    check_zero("clr_entry");
    enter(24'h000000);
    nop();
    check("clr_pw_revert", 32'(bus.state), 32'd3);

    do_set();
    key_in(4'd7); key_in(4'd7); key_in(4'd7);
    do_cancel();
    check("set_cancel", 32'(bus.state), 32'd3);
    ticks(OPEN_TICKS);
    enter(24'h000000);
    nop();
    check("set_cancel_pw", 32'(bus.state), 32'd3);

    do_set();
    enter(24'h111111);
    ticks(OPEN_TICKS);
    wrong_entry(); wrong_entry(); wrong_entry();
    check("lock2_state", 32'(bus.state), 32'd6);
    do_clr();
    check_zero("clr_lock");
    enter(24'h000000);
    nop();
    check("clr_lock_pw", 32'(bus.state), 32'd3);

    for (int i = 0; i < 300; i++) begin
      step(0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           4'($urandom_range(0, 15)), $urandom_range(0, 15) == 0,
           $urandom_range(0, 7) == 0);
    end

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
- Central controller for the six-digit electronic lock. Sequences keypad digit entry, the compare against the stored password, password change, error counting and timed lockout.
- Owns the stored-password and entry-buffer registers. Drives the display nibbles, the unlock output and the alarm LED enable.
- Sits between the keypad/debounce front end and the display/LED flasher; the tick input comes from the existing timer block.

Parameters:
- DIGITS, 6, number of password digits (display width = 4*DIGITS).
- MAX_ERR, 3, consecutive failed attempts that trigger lockout (1..3).
- LOCK_TICKS, 10, tick pulses spent in LOCKOUT.
- OPEN_TICKS, 5, tick pulses spent in OPEN with no key activity.

Ports:
- clk  in  1  system clock, all logic on posedge.
- clr  in  1  synchronous active-high reset.
- tick  in  1  one-cycle strobe from the timer (e.g. 1 Hz).
- key_valid  in  1  one-cycle strobe; key is valid this cycle.
- key  in  4  digit code; 0..9 legal, 10..15 illegal.
- cancel  in  1  one-cycle strobe; aborts the current entry.
- set_req  in  1  one-cycle strobe; request a password change (honoured only in OPEN).
- disp  out  4*DIGITS  display nibbles; digit 1 in the MS nibble.
- digit_cnt  out  3  digits captured in the current entry.
- unlocked  out  1  high in OPEN and SET.
- alarm  out  1  high in LOCKOUT; drives the LED flasher start input.
- err_cnt  out  2  consecutive failures.
- key_err  out  1  one-cycle pulse on an illegal key.
- state  out  3  IDLE=0, ENTRY=1, CHECK=2, OPEN=3, SET=4, FAIL=5, LOCKOUT=6.

Behaviour:
- Reset (clr=1 at posedge, overrides everything):
  - state=IDLE; stored password = all zero; buffer, disp, digit_cnt, err_cnt, tick counter all 0; unlocked, alarm, key_err 0.
- Illegal key (key_valid=1, key>9):
  - In IDLE, ENTRY or SET: key_err=1 the next cycle; digit discarded; digit_cnt and state unchanged.
  - In any other state: ignored, no key_err.
- IDLE:
  - Legal key: write it into buffer nibble 1, digit_cnt=1, go to ENTRY.
  - set_req ignored.
- ENTRY:
  - Each legal key fills the next nibble, MS first, and increments digit_cnt.
  - The DIGITS-th key goes to CHECK.
  - cancel: clear buffer, digit_cnt=0, go to IDLE; err_cnt unchanged.
  - cancel and key_valid in the same cycle: cancel wins.
- CHECK (exactly 1 cycle):
  - Buffer == stored: err_cnt=0, go to OPEN.
  - Otherwise: go to FAIL.
- FAIL (exactly 1 cycle):
  - err_cnt+1 == MAX_ERR: go to LOCKOUT.
  - Otherwise: err_cnt+1, clear buffer, go to IDLE.
- OPEN:
  - unlocked=1 and the tick counter is cleared on entry.
  - Ticks counted from the cycle after entry; after OPEN_TICKS ticks go to IDLE and clear buffer.
  - Keys, cancel and illegal keys ignored.
  - set_req: clear buffer, digit_cnt=0, go to SET.
- SET:
  - unlocked=1; keys are captured exactly as in ENTRY.
  - The DIGITS-th legal key copies the buffer (including that digit) to the stored password in the same edge, then goes to OPEN and restarts the tick counter.
  - cancel: return to OPEN with the stored password unchanged and the tick counter restarted.
  - tick ignored in SET.
- LOCKOUT:
  - alarm=1; disp = all 4'hE; all inputs except tick and clr ignored.
  - After LOCK_TICKS ticks: err_cnt=0, clear buffer, go to IDLE.
  - err_cnt holds MAX_ERR-1 while in LOCKOUT; it does not wrap.
- disp: shows the buffer in all states except LOCKOUT; unfilled nibbles read 0.
- Outputs are registered; keypad-to-display latency is 1 cycle.
- clr mid-entry or in LOCKOUT returns to reset values in 1 cycle.
  - This also clears the stored password.

Test Plan:
- clr, then keys 0,0,0,0,0,0 → CHECK at cycle 7, OPEN at cycle 8; unlocked=1; err_cnt=0.
- In OPEN: set_req, then 1,2,3,4,5,6 → back to OPEN; OPEN_TICKS ticks → IDLE. Then 1,2,3,4,5,6 → OPEN; 1,2,3,4,5,7 → FAIL, err_cnt=1.
- Three wrong entries → LOCKOUT; alarm=1; disp=24'hEEEEEE; keys ignored. 10 ticks → IDLE, err_cnt=0, alarm=0.
- Keys 1,2, then key=4'hB → key_err pulse, digit_cnt stays 2. Then cancel with key_valid in the same cycle → IDLE, digit_cnt=0, err_cnt unchanged.
- SET after 3 digits, then cancel → OPEN; entering 0,0,0,0,0,0 still unlocks.
- clr asserted in LOCKOUT and mid-ENTRY → all outputs zero next cycle; password reverts to 000000.
